led_green_fader: RTL and testbench
==================================

LED_GREEN_FADER -- requirements
Module: led_green_fader

Interface
REQ-001 SHALL have parameter PRESCALE, default 195: clk cycles per PWM step, legal range 1..65535.
REQ-002 SHALL have parameter FADE_STEP, default 16: duty change per PWM period, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state is in this domain.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port led_in, input, 9 bits: target LED pattern, driven by the green-LED PIO out_port in the same clk domain.
REQ-006 SHALL have port bypass, input, 1 bit: 1 = no fading, duties jump to target.
REQ-007 SHALL have port ledg, output, 9 bits: PWM-modulated drive to the board LEDG[8:0] pins, registered.
REQ-008 SHALL have port settled, output, 1 bit: 1 when every duty equals its target, registered.

Function
REQ-009 SHALL register led_in into led_q every cycle; all other logic SHALL use led_q.
REQ-010 SHALL keep prescaler pre_cnt counting 0..PRESCALE-1 and wrapping to 0; tick SHALL be 1 when pre_cnt==PRESCALE-1; PRESCALE=1 SHALL give tick every cycle.
REQ-011 SHALL advance 8-bit pwm_cnt by 1 on tick, wrapping 255->0; period_end SHALL be tick && pwm_cnt==255.
REQ-012 SHALL hold one 8-bit duty[i] per LED (i=0..8), where target(i) is 255 if led_q[i]=1 and 0 otherwise.
REQ-013 When bypass=0 and period_end=1, SHALL set duty[i] to min(255, duty[i]+FADE_STEP) if led_q[i]=1, else max(0, duty[i]-FADE_STEP); arithmetic SHALL be 9-bit saturating, with no wrap-around.
REQ-014 When bypass=1, SHALL load duty[i] with target(i) every cycle, regardless of tick.
REQ-015 When bypass=0 and period_end=0, duty[i] SHALL hold.
REQ-016 SHALL register ledg[i] each cycle as 1 if duty[i]==255, else (pwm_cnt < duty[i]); duty 0 SHALL give constant 0 and duty 255 SHALL give constant 1.
REQ-017 SHALL register settled each cycle as AND over i of (duty[i]==target(i)), using the pre-update duty values.
REQ-018 A led_in change SHALL take 2 cycles to affect the duty update (led_q capture, then update on the next period_end); duties SHALL be evaluated per-LED independently.
REQ-019 A led_in change in the same cycle as period_end SHALL take effect at the following period_end, not the current one.
REQ-020 Toggling led_in mid-fade SHALL reverse that LED's direction from its current duty, with no restart from 0 or 255.
REQ-021 Deasserting bypass SHALL resume fading from the current duty values, with no glitch in pre_cnt or pwm_cnt.

Reset
REQ-022 While reset=1, led_q, pre_cnt, pwm_cnt and all duty[i] SHALL be 0, ledg SHALL be 9'h000 and settled SHALL be 1, asynchronously to clk.
REQ-023 Deassertion of reset SHALL start counting from pre_cnt=0 and pwm_cnt=0 on the first rising clk edge.
REQ-024 Reset asserted mid-fade SHALL abandon the fade immediately, with no residual duty state.

Verification (PRESCALE=1, FADE_STEP=16 unless stated)
REQ-025 Reset release, led_in=0 -> ledg=9'h000 and settled=1 indefinitely.
REQ-026 led_in=9'h001, bypass=0 -> settled=0 within 2 cycles; duty[0] steps 16,32,...,240,255 on successive period_ends (16 periods); settled=1 after the 255 step; ledg[0] is constantly 1 thereafter.
REQ-027 led_in=9'h1FF with bypass=1 -> ledg=9'h1FF by cycle 3 and settled=1; then bypass=0 with led_in=0 -> all duties ramp down to 0 over 16 periods.
REQ-028 duty[4]=128 steady (ramp up, then freeze via bypass toggle timing) -> ledg[4] high for exactly 128 of 256 cycles per period.
REQ-029 Flip led_in[2] from 1 to 0 when duty[2]=96 -> next period_end gives 80, with no jump.
REQ-030 Assert reset for 1 cycle mid-ramp with PRESCALE=3 -> all outputs at reset values immediately; after release the first tick occurs on the 3rd clk edge.

Source files
------------

// File: rtl/led_green_fader.sv
// led_green_fader: per-LED PWM fader for the nine green board LEDs.
// Each LED owns an 8-bit duty that ramps toward 0 or 255 by FADE_STEP once
// per 256-step PWM period, or jumps straight to its target in bypass mode.
module led_green_fader #(
  parameter int unsigned PRESCALE  = 195,
  parameter int unsigned FADE_STEP = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] led_in,
  input  logic       bypass,
  output logic [8:0] ledg,
  output logic       settled
);

  localparam int unsigned N_LED  = 9;
  localparam int unsigned PRE_W  = 16;
  localparam int unsigned DUTY_W = 8;

  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [DUTY_W:0]   STEP     = (DUTY_W + 1)'(FADE_STEP);
  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;
  localparam logic [DUTY_W-1:0] DUTY_MIN = '0;
  localparam logic [DUTY_W-1:0] PWM_LAST = '1;

  logic [N_LED-1:0]             led_q;
  logic [PRE_W-1:0]             pre_cnt;
  logic [DUTY_W-1:0]            pwm_cnt;
  logic [N_LED-1:0][DUTY_W-1:0] duty;

  logic                         tick_c;
  logic                         period_end_c;
  logic [N_LED-1:0][DUTY_W-1:0] duty_next_c;
  logic [N_LED-1:0]             ledg_next_c;
  logic [N_LED-1:0]             match_c;

  // Prescaler terminal count marks one PWM step; a full PWM wrap ends a period.
  assign tick_c       = (pre_cnt == PRE_LAST);
  assign period_end_c = tick_c && (pwm_cnt == PWM_LAST);

  // Capture the PIO pattern once so every LED sees the same sampled target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q <= '0;
    end else begin
      led_q <= led_in;
    end
  end

  // Prescaler: counts 0..PRESCALE-1; with PRESCALE=1 it sits at 0 and ticks every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (tick_c) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // PWM phase counter, free-running 0..255 and advancing once per tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else if (tick_c) begin
      pwm_cnt <= pwm_cnt + DUTY_W'(1);
    end
  end

  // Per-LED channel: saturating step, next duty, PWM compare and settle match.
  for (genvar g = 0; g < N_LED; g++) begin : g_ch
    logic [DUTY_W:0]   sum_c;
    logic [DUTY_W:0]   diff_c;
    logic [DUTY_W-1:0] up_c;
    logic [DUTY_W-1:0] dn_c;
    logic [DUTY_W-1:0] target_c;

    // 9-bit arithmetic: bit 8 flags overflow on the way up and borrow on the way down.
    assign sum_c    = {1'b0, duty[g]} + STEP;
    assign diff_c   = {1'b0, duty[g]} - STEP;
    assign up_c     = sum_c[DUTY_W]  ? DUTY_MAX : sum_c[DUTY_W-1:0];
    assign dn_c     = diff_c[DUTY_W] ? DUTY_MIN : diff_c[DUTY_W-1:0];
    assign target_c = led_q[g] ? DUTY_MAX : DUTY_MIN;

    // Bypass wins over fading; otherwise duties only move at a period boundary.
    always_comb begin
      duty_next_c[g] = duty[g];
      if (bypass) begin
        duty_next_c[g] = target_c;
      end else if (period_end_c) begin
        duty_next_c[g] = led_q[g] ? up_c : dn_c;
      end
    end

    // Full duty forces a solid 1 so the LED never blinks at the pwm_cnt=255 step.
    assign ledg_next_c[g] = (duty[g] == DUTY_MAX) || (pwm_cnt < duty[g]);
    assign match_c[g]     = (duty[g] == target_c);
  end

  // Duty storage for all nine channels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty <= '0;
    end else begin
      duty <= duty_next_c;
    end
  end

  // Registered outputs, derived from the duties before this cycle's update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ledg    <= '0;
      settled <= 1'b1;
    end else begin
      ledg    <= ledg_next_c;
      settled <= &match_c;
    end
  end

endmodule

// File: tb/tb_led_green_fader.sv
// tb_led_green_fader: scenario tasks against two fader instances
// (PRESCALE=1 and PRESCALE=3) plus a cycle-count based reference model.
module tb_led_green_fader;

  localparam int FADE = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] led_in;
  logic       bypass;
  logic [8:0] ledg1, ledg3;
  logic       settled1, settled3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  led_green_fader #(.PRESCALE(1), .FADE_STEP(16)) dut1 (
    .clk(clk), .reset(reset), .led_in(led_in), .bypass(bypass),
    .ledg(ledg1), .settled(settled1)
  );

  led_green_fader #(.PRESCALE(3), .FADE_STEP(16)) dut3 (
    .clk(clk), .reset(reset), .led_in(led_in), .bypass(bypass),
    .ledg(ledg3), .settled(settled3)
  );

  // Reference state: counter phase is derived from the cycle count since reset.
  typedef struct packed {
    int             cyc;
    logic [8:0][7:0] duty;
    logic [8:0]     led_q;
    logic [8:0]     ledg;
    logic           settled;
    logic           pe;
  } model_t;

  model_t m0, m3;

  function automatic model_t model_rst();
    model_t n;
    n = '0;
    n.settled = 1'b1;
    return n;
  endfunction

  function automatic model_t model_step(input model_t s, input int p,
                                        input logic [8:0] lin, input logic byp);
    model_t n;
    int pwm, d, tgt;
    bit pe, all_eq;
    n = s;
    pwm = (s.cyc / p) % 256;
    pe = ((s.cyc % p) == p - 1) && (pwm == 255);
    all_eq = 1'b1;
    for (int i = 0; i < 9; i++) begin
      d = int'(s.duty[i]);
      tgt = s.led_q[i] ? 255 : 0;
      n.ledg[i] = (d == 255) || (pwm < d);
      if (d != tgt) all_eq = 1'b0;
      if (byp) d = tgt;
      else if (pe) d = s.led_q[i] ? ((d + FADE > 255) ? 255 : d + FADE)
                                  : ((d - FADE < 0) ? 0 : d - FADE);
      n.duty[i] = 8'(d);
    end
    n.settled = all_eq;
    n.led_q = lin;
    n.pe = pe;
    n.cyc = s.cyc + 1;
    return n;
  endfunction

  // Reference advances on the same edges as the designs.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m0 <= model_rst();
      m3 <= model_rst();
    end else begin
      m0 <= model_step(m0, 1, led_in, bypass);
      m3 <= model_step(m3, 3, led_in, bypass);
    end
  end

  task automatic test_reset();
    bit mism;
    reset = 1'b1; led_in = '0; bypass = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (ledg1 !== 9'h000 || settled1 !== 1'b1) begin
      fails++; $display("FAIL reset_p1: ledg=%h settled=%b expected 000/1", ledg1, settled1);
    end
    tests++;
    if (ledg3 !== 9'h000 || settled3 !== 1'b1) begin
      fails++; $display("FAIL reset_p3: ledg=%h settled=%b expected 000/1", ledg3, settled3);
    end
    reset = 1'b0;
    mism = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (ledg1 !== 9'h000 || settled1 !== 1'b1) mism = 1'b1;
    end
    tests++;
    if (mism) begin
      fails++; $display("FAIL idle_after_reset: ledg=%h settled=%b expected 000/1", ledg1, settled1);
    end
  endtask

  task automatic test_ramp_up();
    int hi, exp_d, exp_hi;
    bit found, mism;
    led_in = 9'h001; bypass = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (settled1 !== 1'b0) begin
      fails++; $display("FAIL ramp_settled_drop: got %b expected 0", settled1);
    end
    found = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (m0.pe && m0.duty[0] == 8'd16) begin found = 1'b1; break; end
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL ramp_first_step: no period_end within 600 cycles");
    end
    for (int k = 1; k <= 16; k++) begin
      exp_d = (16 * k > 255) ? 255 : 16 * k;
      exp_hi = (exp_d == 255) ? 256 : exp_d;
      hi = 0; mism = 1'b0;
      for (int c = 0; c < 256; c++) begin
        @(negedge clk);
        if (ledg1[0] === 1'b1) hi++;
        if (ledg1 !== m0.ledg || settled1 !== m0.settled) mism = 1'b1;
      end
      tests++;
      if (hi != exp_hi) begin
        fails++; $display("FAIL ramp_up_window%0d: high=%0d expected %0d", k, hi, exp_hi);
      end
      tests++;
      if (mism) begin
        fails++; $display("FAIL ramp_up_model%0d: ledg=%h expected %h", k, ledg1, m0.ledg);
      end
    end
    tests++;
    if (settled1 !== 1'b1) begin
      fails++; $display("FAIL ramp_settled_end: got %b expected 1", settled1);
    end
    mism = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (ledg1 !== 9'h001 || settled1 !== 1'b1) mism = 1'b1;
    end
    tests++;
    if (mism) begin
      fails++; $display("FAIL ramp_full_on: ledg=%h settled=%b expected 001/1", ledg1, settled1);
    end
  endtask

  task automatic test_bypass();
    int hi, exp_hi;
    bit found, mism;
    led_in = 9'h1FF; bypass = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (ledg1 !== 9'h1FF) begin
      fails++; $display("FAIL bypass_jump: ledg=%h expected 1ff", ledg1);
    end
    tests++;
    if (settled1 !== 1'b1) begin
      fails++; $display("FAIL bypass_settled: got %b expected 1", settled1);
    end
    bypass = 1'b0; led_in = 9'h000;
    found = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (m0.pe && m0.duty[8] == 8'd239) begin found = 1'b1; break; end
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL ramp_down_start: no period_end within 600 cycles");
    end
    for (int k = 1; k <= 16; k++) begin
      exp_hi = (255 - 16 * k < 0) ? 0 : 255 - 16 * k;
      hi = 0; mism = 1'b0;
      for (int c = 0; c < 256; c++) begin
        @(negedge clk);
        if (ledg1[8] === 1'b1) hi++;
        if (ledg1 !== m0.ledg || settled1 !== m0.settled) mism = 1'b1;
      end
      tests++;
      if (hi != exp_hi) begin
        fails++; $display("FAIL ramp_down_window%0d: high=%0d expected %0d", k, hi, exp_hi);
      end
      tests++;
      if (mism) begin
        fails++; $display("FAIL ramp_down_model%0d: ledg=%h expected %h", k, ledg1, m0.ledg);
      end
    end
    mism = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (ledg1 !== 9'h000 || settled1 !== 1'b1) mism = 1'b1;
    end
    tests++;
    if (mism) begin
      fails++; $display("FAIL ramp_down_off: ledg=%h settled=%b expected 000/1", ledg1, settled1);
    end
  endtask

  task automatic test_half_duty();
    int hi;
    bit found;
    led_in = 9'h010;
    found = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (m0.pe && m0.duty[4] == 8'd16) begin found = 1'b1; break; end
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL half_start: no period_end within 600 cycles");
    end
    for (int k = 1; k <= 8; k++) begin
      hi = 0;
      for (int c = 0; c < 256; c++) begin
        @(negedge clk);
        if (ledg1[4] === 1'b1) hi++;
      end
      tests++;
      if (hi != 16 * k) begin
        fails++; $display("FAIL half_window%0d: high=%0d expected %0d", k, hi, 16 * k);
      end
    end
  endtask

  task automatic test_reverse();
    int hi;
    int seq[4];
    bit found, mism;
    seq = '{96, 80, 64, 80};
    led_in = 9'h004;
    found = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (m0.pe && m0.duty[2] == 8'd16) begin found = 1'b1; break; end
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL reverse_start: no period_end within 600 cycles");
    end
    for (int k = 1; k <= 5; k++) begin
      hi = 0;
      for (int c = 0; c < 256; c++) begin
        @(negedge clk);
        if (ledg1[2] === 1'b1) hi++;
      end
      tests++;
      if (hi != 16 * k) begin
        fails++; $display("FAIL reverse_up%0d: high=%0d expected %0d", k, hi, 16 * k);
      end
    end
    // duty[2] is now 96: reverse it, then re-raise it in the period_end cycle itself
    led_in = 9'h000;
    for (int w = 0; w < 4; w++) begin
      hi = 0; mism = 1'b0;
      for (int c = 0; c < 256; c++) begin
        @(negedge clk);
        if (ledg1[2] === 1'b1) hi++;
        if (ledg1 !== m0.ledg || settled1 !== m0.settled) mism = 1'b1;
        if (w == 1 && c == 254) led_in = 9'h004;
      end
      tests++;
      if (hi != seq[w]) begin
        fails++; $display("FAIL reverse_window%0d: high=%0d expected %0d", w, hi, seq[w]);
      end
      tests++;
      if (mism) begin
        fails++; $display("FAIL reverse_model%0d: ledg=%h expected %h", w, ledg1, m0.ledg);
      end
    end
  endtask

  task automatic test_random();
    bit mism;
    for (int blk = 0; blk < 12; blk++) begin
      mism = 1'b0;
      for (int c = 0; c < 256; c++) begin
        @(negedge clk);
        if (ledg1 !== m0.ledg || settled1 !== m0.settled) mism = 1'b1;
        if (ledg3 !== m3.ledg || settled3 !== m3.settled) mism = 1'b1;
        if ($urandom_range(0, 63) == 0) led_in = 9'($urandom);
        if ($urandom_range(0, 99) == 0) bypass = ~bypass;
      end
      tests++;
      if (mism) begin
        fails++;
        $display("FAIL random_blk%0d: ledg1=%h/%h ledg3=%h/%h (actual/required)",
                 blk, ledg1, m0.ledg, ledg3, m3.ledg);
      end
    end
    bypass = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit mism;
    int exp_pwm[3];
    exp_pwm = '{0, 0, 1};
    led_in = 9'h1FF; bypass = 1'b0;
    mism = 1'b0;
    for (int c = 0; c < 1600 + int'($urandom_range(0, 200)); c++) begin
      @(negedge clk);
      if (ledg3 !== m3.ledg || settled3 !== m3.settled) mism = 1'b1;
      if (ledg1 !== m0.ledg || settled1 !== m0.settled) mism = 1'b1;
    end
    tests++;
    if (mism) begin
      fails++; $display("FAIL premid_model: ledg3=%h expected %h", ledg3, m3.ledg);
    end
    tests++;
    if (dut3.duty !== m3.duty) begin
      fails++; $display("FAIL premid_duty: got %h expected %h", dut3.duty, m3.duty);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (ledg1 !== 9'h000 || settled1 !== 1'b1 || ledg3 !== 9'h000 || settled3 !== 1'b1) begin
      fails++;
      $display("FAIL async_reset_out: ledg1=%h s1=%b ledg3=%h s3=%b expected 000/1",
               ledg1, settled1, ledg3, settled3);
    end
    tests++;
    if (dut3.duty !== '0 || dut3.pwm_cnt !== 8'd0 || dut3.pre_cnt !== 16'd0) begin
      fails++;
      $display("FAIL async_reset_state: duty=%h pwm=%0d pre=%0d expected 0",
               dut3.duty, dut3.pwm_cnt, dut3.pre_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    led_in = 9'($urandom) | 9'h001;
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      tests++;
      if (dut3.pwm_cnt !== 8'(exp_pwm[e])) begin
        fails++;
        $display("FAIL first_tick_edge%0d: pwm=%0d expected %0d", e + 1, dut3.pwm_cnt, exp_pwm[e]);
      end
    end
    mism = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (ledg3 !== m3.ledg || settled3 !== m3.settled) mism = 1'b1;
      if (ledg1 !== m0.ledg || settled1 !== m0.settled) mism = 1'b1;
    end
    tests++;
    if (mism) begin
      fails++; $display("FAIL post_reset_model: ledg3=%h expected %h", ledg3, m3.ledg);
    end
  endtask

  initial begin
    reset = 1'b1;
    led_in = '0;
    bypass = 1'b0;
    test_reset();
    test_ramp_up();
    test_bypass();
    test_half_duty();
    test_reverse();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
